// File: rtl/vc_entry_array.sv
// vc_entry_array: fully associative victim-line store with age-based LRU and dirty writeback to L2.
// Optional statistics counters (hit/ins/wb) are compiled in when VC_STATS_EN is defined.
module vc_entry_array #(
  parameter int entries = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
`ifdef VC_STATS_EN
  output logic [31:0]                hit_count,
  output logic [31:0]                ins_count,
  output logic [31:0]                wb_count,
`endif
  input  logic                       ins_valid,
  output logic                       ins_ready,
  input  logic [31:0]                ins_address,
  input  logic [255:0]               ins_data,
  input  logic                       ins_dirty,
  input  logic [31:0]                lk_address,
  output logic                       lk_hit,
  output logic [$clog2(entries)-1:0] lk_index,
  output logic                       lk_dirty,
  input  logic                       lk_take,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [31:0]                wb_address,
  output logic [255:0]               wb_data,
  output logic [entries-1:0]         valid_outs,
  output logic [entries*32-1:0]      address_outs,
  output logic [entries*256-1:0]     data_outs
);
  localparam int IW = $clog2(entries);

  typedef enum logic {IDLE, WB} state_t;
  state_t state_q, state_d;

  logic [entries-1:0] valid_q, dirty_q;
  logic [26:0]        addr_q [entries];
  logic [255:0]       data_q [entries];
  logic [IW-1:0]      age_q  [entries];

  logic [26:0]        pend_addr_q;
  logic [255:0]       pend_data_q;
  logic               pend_dirty_q;
  logic [IW-1:0]      victim_q;

  logic               sel_found;
  logic [IW-1:0]      sel_idx;
  logic               wr_en, latch_en, clr_en, touch_en;
  logic [IW-1:0]      wr_idx, touch_idx;
  logic [26:0]        wr_addr;
  logic [255:0]       wr_data;
  logic               wr_dirty;
  logic               ins_fire, take_fire, wb_fire;
  logic               ins_dup;

  // Lookup is suppressed in WB so a take can never disturb the pending victim.
  always_comb begin
    logic found;
    found    = 1'b0;
    lk_index = '0;
    lk_dirty = 1'b0;
    for (int unsigned i = 0; i < entries; i++) begin
      if (!found && valid_q[i] && addr_q[i] == lk_address[31:5] && state_q == IDLE) begin
        found    = 1'b1;
        lk_index = IW'(i);
        lk_dirty = dirty_q[i];
      end
    end
    lk_hit = found;
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < entries; i++) begin
      if (!sel_found && !valid_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
    if (!sel_found) begin
      for (int unsigned i = 0; i < entries; i++) begin
        if (age_q[i] == IW'(entries - 1)) sel_idx = IW'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ins_ready = 1'b0;
    wb_valid  = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = sel_idx;
    wr_addr   = ins_address[31:5];
    wr_data   = ins_data;
    wr_dirty  = ins_dirty;
    latch_en  = 1'b0;
    clr_en    = 1'b0;
    touch_en  = 1'b0;
    touch_idx = sel_idx;
    ins_fire  = 1'b0;
    take_fire = 1'b0;
    wb_fire   = 1'b0;
    case (state_q)
      IDLE: begin
        ins_ready = !lk_take;
        if (ins_valid && !lk_take) begin
          ins_fire = 1'b1;
          if (valid_q[sel_idx] && dirty_q[sel_idx]) begin
            latch_en = 1'b1;
            state_d  = WB;
          end else begin
            wr_en    = 1'b1;
            touch_en = 1'b1;
          end
        end else if (lk_take && lk_hit) begin
          take_fire = 1'b1;
          clr_en    = 1'b1;
          touch_en  = 1'b1;
          touch_idx = lk_index;
        end
      end
      WB: begin
        wb_valid = 1'b1;
        if (wb_ready) begin
          wb_fire   = 1'b1;
          wr_en     = 1'b1;
          wr_idx    = victim_q;
          wr_addr   = pend_addr_q;
          wr_data   = pend_data_q;
          wr_dirty  = pend_dirty_q;
          touch_en  = 1'b1;
          touch_idx = victim_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wb_address = wb_valid ? {addr_q[victim_q], 5'b0} : '0;
  assign wb_data    = wb_valid ? data_q[victim_q] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      pend_dirty_q <= 1'b0;
      victim_q     <= '0;
      for (int unsigned i = 0; i < entries; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        age_q[i]  <= IW'(i);
      end
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        pend_addr_q  <= ins_address[31:5];
        pend_data_q  <= ins_data;
        pend_dirty_q <= ins_dirty;
        victim_q     <= sel_idx;
      end
      if (wr_en) begin
        valid_q[wr_idx] <= 1'b1;
        dirty_q[wr_idx] <= wr_dirty;
        addr_q[wr_idx]  <= wr_addr;
        data_q[wr_idx]  <= wr_data;
      end
      if (clr_en) begin
        valid_q[touch_idx] <= 1'b0;
        dirty_q[touch_idx] <= 1'b0;
      end
      // Touch: entries younger than the touched one age by one, keeping ages a permutation.
      if (touch_en) begin
        for (int unsigned i = 0; i < entries; i++) begin
          if (IW'(i) == touch_idx)                age_q[i] <= '0;
          else if (age_q[i] < age_q[touch_idx])  age_q[i] <= age_q[i] + IW'(1);
        end
      end
    end
  end

  always_comb begin
    valid_outs = valid_q;
    for (int unsigned i = 0; i < entries; i++) begin
      address_outs[i*32 +: 32]  = {addr_q[i], 5'b0};
      data_outs[i*256 +: 256]   = data_q[i];
    end
  end

`ifdef VC_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count <= '0;
      ins_count <= '0;
      wb_count  <= '0;
    end else begin
      if (take_fire) hit_count <= hit_count + 32'd1;
      if (ins_fire)  ins_count <= ins_count + 32'd1;
      if (wb_fire)   wb_count  <= wb_count + 32'd1;
    end
  end
`endif

  always_comb begin
    ins_dup = 1'b0;
    for (int unsigned i = 0; i < entries; i++)
      if (valid_q[i] && addr_q[i] == ins_address[31:5]) ins_dup = 1'b1;
  end

  a_no_dup_insert: assert property (@(posedge clk) disable iff (!rst_n)
    (ins_valid && ins_ready) |-> !ins_dup);

endmodule

// File: doc/vc_entry_array.md
# vc_entry_array

Storage and replacement core of the victim cache. It holds the fully associative victim lines evicted from L1 and answers L1 lookups, removing a line when L1 reclaims it. When a new victim arrives and the array is full, it writes back the dirty LRU line to L2. Its `address_outs`/`data_outs` buses drive `vc_t_assigner` directly.

## Interface
- `entries`, 8, number of victim lines; must be a power of 2 and at least 2.
- `clk`  in  1  clock, rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ins_valid`  in  1  L1 eviction offered.
- `ins_ready`  out  1  array accepts an insert this cycle.
- `ins_address`  in  32  line address of the eviction; bits [4:0] are ignored and stored as 0.
- `ins_data`  in  256  line data.
- `ins_dirty`  in  1  the line is modified.
- `lk_address`  in  32  L1 lookup address; only bits [31:5] are compared.
- `lk_hit`  out  1  a valid entry matches (combinational).
- `lk_index`  out  $clog2(entries)  index of the matching entry; 0 on a miss.
- `lk_dirty`  out  1  dirty bit of the matching entry; 0 on a miss.
- `lk_take`  in  1  L1 reclaims the hit line; the line is invalidated at the edge.
- `wb_valid`  out  1  a dirty victim is presented to L2.
- `wb_ready`  in  1  L2 accepts the writeback.
- `wb_address`  out  32  victim line address.
- `wb_data`  out  256  victim line data.
- `valid_outs`  out  entries  per-entry valid bits.
- `address_outs`  out  entries×32  per-entry stored address (packed, entry 0 in the LSBs).
- `data_outs`  out  entries×256  per-entry stored data (packed).
- `hit_count`, `ins_count`, `wb_count`  out  32 each  statistics; present only with `VC_STATS_EN`.

## Operation
- Per-entry state: valid, dirty, address[31:5], data, and age[$clog2(entries)-1:0]. Ages always form a permutation of 0..entries-1. Age 0 marks the MRU entry and age entries-1 marks the LRU entry.
- Touch(i): every entry with age < age[i] increments its age, and age[i] is set to 0. Inserts and hits that are taken cause a touch. Lookups without a take do not change ages.
- Slot selection: the lowest-indexed invalid entry. If every entry is valid, the entry with age entries-1 is selected.
- FSM has two states, IDLE and WB.
  - IDLE: `ins_ready = !lk_take`. When an insert is accepted and the selected slot is invalid or clean, the line is written at that edge, dirty is set to `ins_dirty`, the slot is touched, and the FSM stays in IDLE. If the selected slot is valid and dirty, the FSM latches the insert and the victim index and moves to WB.
  - WB: `ins_ready = 0`. `wb_valid` is 1, and `wb_address`/`wb_data` come from the victim entry. On the edge where `wb_valid && wb_ready`, the latched insert overwrites the victim slot, the slot is touched, and the FSM returns to IDLE.
- Take: in IDLE, `lk_take && lk_hit` clears the valid and dirty bits of entry `lk_index` and touches it. `lk_take` without a hit has no effect. In WB, `lk_hit` is forced to 0 and `lk_take` is ignored.
- Because `ins_ready` is low while `lk_take` is high, a take and an insert never occur in the same cycle.
- An insert whose address already matches a valid entry is a protocol violation and is covered by an assertion. Upstream guarantees this never happens.
- `wb_address`/`wb_data` are 0 whenever `wb_valid` is 0.

## Timing
- Reset values: valid=0, dirty=0, age[i]=i, all address/data registers 0, state IDLE, `wb_valid`=0, counters 0. Consequently `ins_ready`=1 out of reset (when `lk_take` is low) and `lk_hit`=0.
- Reset asserted mid-WB aborts the writeback. `wb_valid` drops immediately and the latched insert is discarded.
- `lk_hit`, `lk_index` and `lk_dirty` have zero-cycle latency from `lk_address`.
- Stored state becomes visible on `*_outs` the cycle after the write edge.
- A clean or free insert takes 1 cycle, and back-to-back inserts are supported at 1 per cycle.
- A dirty-victim insert takes 1 cycle in IDLE plus at least 1 cycle in WB. `wb_valid` rises the cycle after acceptance and holds stable until `wb_ready` is seen.

## Configuration
- `VC_STATS_EN` defined: the three 32-bit counters are present and wrap at 2^32.
  - `hit_count` increments on every taken hit.
  - `ins_count` increments on every accepted insert.
  - `wb_count` increments on every writeback handshake.
- `VC_STATS_EN` undefined: the counters are not compiled in, their ports are absent, and the rest of the behaviour is identical.

## Test plan
- Reset, then insert 0x0000_1020 (clean) → one cycle later `valid_outs`=0x01, `address_outs[0]`=0x0000_1020, `ins_ready`=1.
- Fill entries=8 with clean lines A0..A7, then insert A8 → entry 0 (the LRU) is replaced in 1 cycle and `wb_valid` stays 0.
- Fill with A0 dirty, then insert A8 → `wb_valid`=1 with `wb_address`=A0. Hold `wb_ready`=0 for 3 cycles: `wb_valid` stays 1 and the outputs stay stable. On the handshake, entry 0 becomes A8 and the FSM returns to IDLE.
- With A3 in entry 3, drive `lk_address`=A3|0x1F → `lk_hit`=1, `lk_index`=3. Pulse `lk_take` → entry 3 is invalidated, `ins_ready`=0 during the take cycle, and the next insert lands in slot 3.
- Lookup during WB → `lk_hit`=0. Assert `rst_n`=0 mid-WB → `wb_valid`=0 immediately and `valid_outs`=0.
- With `VC_STATS_EN`: 5 inserts, 2 taken hits and 1 writeback → counts 5/2/1.
